// File: rtl/demo_pkg.sv
// demo_pkg: shared types and widths for the demo scene sequencer
package demo_pkg;
  typedef enum logic [1:0] {FADE_IN, HOLD, FADE_OUT, NEXT} state_t;
  localparam int SCROLL_W = 10;
  localparam int FADE_W = 2;
  localparam int SCENE_W = 2;
endpackage

// File: rtl/demo_scene_sequencer_vsync_edge.sv
// vsync_edge: registered one-cycle frame pulse on the vsync assertion edge
module vsync_edge #(
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync,
  output logic frame_tick
);
  logic vsync_q;
  // history starts at the active level so a vsync held active through reset is not an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q <= VSYNC_POL;
      frame_tick <= 1'b0;
    end else begin
      vsync_q <= vsync;
      frame_tick <= (vsync == VSYNC_POL) && (vsync_q != VSYNC_POL);
    end
  end
endmodule

// File: rtl/demo_scene_sequencer.sv
// demo_scene_sequencer: per-frame scene/fade FSM and scroll accumulator for the VGA demo
module demo_scene_sequencer
  import demo_pkg::*;
#(
  parameter int NUM_SCENES = 4,
  parameter int HOLD_FRAMES = 240,
  parameter int FADE_FRAMES = 8,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                vsync,
  input  logic                pause,
  input  logic                step_next,
  input  logic [1:0]          speed,
  output logic                frame_tick,
  output logic [SCENE_W-1:0]  scene,
  output logic [FADE_W-1:0]   fade,
  output logic [SCROLL_W-1:0] scroll_x
);
  localparam int CNT_MAX = (HOLD_FRAMES > FADE_FRAMES) ? HOLD_FRAMES : FADE_FRAMES;
  localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] FADE_LAST = CW'(FADE_FRAMES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_FRAMES - 1);
  localparam logic [SCENE_W-1:0] SCENE_LAST = SCENE_W'(NUM_SCENES - 1);
  state_t state, state_n;
  logic [CW-1:0] fcnt, fcnt_n;
  logic [FADE_W-1:0] fade_n;
  logic [SCENE_W-1:0] scene_n;
  logic [SCROLL_W-1:0] scroll_n;
  logic [1:0] pause_s, step_s, speed_m, speed_s;
  logic step_d, step_pending;
  logic tick, step_rise;
  vsync_edge #(.VSYNC_POL(VSYNC_POL)) u_vsync_edge (
    .clk(clk), .rst_n(rst_n), .vsync(vsync), .frame_tick(frame_tick)
  );
  assign tick = frame_tick & ~pause_s[1];
  assign step_rise = step_s[1] & ~step_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pause_s <= '0;
      step_s <= '0;
      step_d <= 1'b0;
      speed_m <= '0;
      speed_s <= '0;
      step_pending <= 1'b0;
      state <= FADE_IN;
      fcnt <= '0;
      fade <= '0;
      scene <= '0;
      scroll_x <= '0;
    end else begin
      pause_s <= {pause_s[0], pause};
      step_s <= {step_s[0], step_next};
      step_d <= step_s[1];
      speed_m <= speed;
      speed_s <= speed_m;
      step_pending <= step_rise | (step_pending & ~tick);
      state <= state_n;
      fcnt <= fcnt_n;
      fade <= fade_n;
      scene <= scene_n;
      scroll_x <= scroll_n;
    end
  end
  always_comb begin
    state_n = state;
    fcnt_n = fcnt;
    fade_n = fade;
    scene_n = scene;
    scroll_n = scroll_x;
    if (tick) begin
      scroll_n = scroll_x + (SCROLL_W'(1) << speed_s);
      fcnt_n = fcnt + 1'b1;
      case (state)
        FADE_IN: begin
          if (step_pending) begin
            fcnt_n = '0;
            state_n = (fade == '0) ? NEXT : FADE_OUT;
          end else if (fcnt == FADE_LAST) begin
            fcnt_n = '0;
            fade_n = fade + 1'b1;
            state_n = (fade == 2'd2) ? HOLD : FADE_IN;
          end
        end
        HOLD: begin
          if (step_pending || fcnt == HOLD_LAST) begin
            fcnt_n = '0;
            state_n = (fade == '0) ? NEXT : FADE_OUT;
          end
        end
        FADE_OUT: begin
          if (fcnt == FADE_LAST) begin
            fcnt_n = '0;
            fade_n = (fade <= 2'd1) ? '0 : fade - 1'b1;
            state_n = (fade <= 2'd1) ? NEXT : FADE_OUT;
          end
        end
        NEXT: begin
          fcnt_n = '0;
          scene_n = (scene == SCENE_LAST) ? '0 : scene + 1'b1;
          state_n = FADE_IN;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_demo_scene_sequencer.sv
// tb_demo_scene_sequencer: directed checks of frame pulses, fade/scene sequence, scroll, step and pause
module tb_demo_scene_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic vsync = 1'b1;
  logic pause = 1'b0;
  logic step_next = 1'b0;
  logic [1:0] speed = 2'd0;
  logic frame_tick;
  logic [1:0] scene, fade;
  logic [9:0] scroll_x;
  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int p0;
  demo_scene_sequencer #(
    .NUM_SCENES(4), .HOLD_FRAMES(4), .FADE_FRAMES(2), .VSYNC_POL(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vsync(vsync), .pause(pause), .step_next(step_next),
    .speed(speed), .frame_tick(frame_tick), .scene(scene), .fade(fade), .scroll_x(scroll_x)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (rst_n && frame_tick) pulses++;
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    vsync = 1'b1;
    pause = 1'b0;
    step_next = 1'b0;
    speed = 2'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask
  task automatic frames(input int n);
    repeat (n) begin
      @(negedge clk);
      vsync = 1'b0;
      repeat (2) @(negedge clk);
      vsync = 1'b1;
      repeat (3) @(negedge clk);
    end
  endtask
  task automatic pulse_step();
    step_next = 1'b1;
    repeat (4) @(negedge clk);
    step_next = 1'b0;
    repeat (4) @(negedge clk);
  endtask
  task automatic test_reset();
    do_reset();
    p0 = pulses;
    repeat (20) @(negedge clk);
    checks++; if (pulses - p0 !== 0) begin errors++; $display("FAIL reset_no_tick got %0d want 0", pulses - p0); end
    checks++; if (scene !== 2'd0) begin errors++; $display("FAIL reset_scene got %0d want 0", scene); end
    checks++; if (fade !== 2'd0) begin errors++; $display("FAIL reset_fade got %0d want 0", fade); end
    checks++; if (scroll_x !== 10'd0) begin errors++; $display("FAIL reset_scroll got %0d want 0", scroll_x); end
  endtask
  task automatic test_sequence();
    do_reset();
    p0 = pulses;
    frames(2);
    checks++; if (fade !== 2'd1) begin errors++; $display("FAIL seq_fade_t2 got %0d want 1", fade); end
    frames(2);
    checks++; if (fade !== 2'd2) begin errors++; $display("FAIL seq_fade_t4 got %0d want 2", fade); end
    frames(2);
    checks++; if (fade !== 2'd3) begin errors++; $display("FAIL seq_fade_t6 got %0d want 3", fade); end
    frames(4);
    checks++; if (fade !== 2'd3) begin errors++; $display("FAIL seq_fade_t10 got %0d want 3", fade); end
    frames(2);
    checks++; if (fade !== 2'd2) begin errors++; $display("FAIL seq_fade_t12 got %0d want 2", fade); end
    frames(2);
    checks++; if (fade !== 2'd1) begin errors++; $display("FAIL seq_fade_t14 got %0d want 1", fade); end
    frames(2);
    checks++; if (fade !== 2'd0) begin errors++; $display("FAIL seq_fade_t16 got %0d want 0", fade); end
    checks++; if (scene !== 2'd0) begin errors++; $display("FAIL seq_scene_t16 got %0d want 0", scene); end
    frames(1);
    checks++; if (scene !== 2'd1) begin errors++; $display("FAIL seq_scene_t17 got %0d want 1", scene); end
    frames(50);
    checks++; if (scene !== 2'd3) begin errors++; $display("FAIL seq_scene_t67 got %0d want 3", scene); end
    frames(1);
    checks++; if (scene !== 2'd0) begin errors++; $display("FAIL seq_scene_wrap got %0d want 0", scene); end
    checks++; if (scroll_x !== 10'd68) begin errors++; $display("FAIL seq_scroll got %0d want 68", scroll_x); end
    checks++; if (pulses - p0 !== 68) begin errors++; $display("FAIL seq_pulses got %0d want 68", pulses - p0); end
  endtask
  task automatic test_scroll();
    do_reset();
    speed = 2'd2;
    repeat (4) @(negedge clk);
    frames(300);
    checks++; if (scroll_x !== 10'd176) begin errors++; $display("FAIL scroll_speed2 got %0d want 176", scroll_x); end
    speed = 2'd0;
    repeat (4) @(negedge clk);
    frames(1024);
    checks++; if (scroll_x !== 10'd176) begin errors++; $display("FAIL scroll_wrap got %0d want 176", scroll_x); end
  endtask
  task automatic test_step();
    do_reset();
    frames(7);
    pulse_step();
    frames(1);
    checks++; if (fade !== 2'd3) begin errors++; $display("FAIL step_hold_fade got %0d want 3", fade); end
    frames(2);
    checks++; if (fade !== 2'd2) begin errors++; $display("FAIL step_hold_early got %0d want 2", fade); end
    do_reset();
    pulse_step();
    frames(1);
    checks++; if (scene !== 2'd0) begin errors++; $display("FAIL step_black_next got %0d want 0", scene); end
    frames(1);
    checks++; if (scene !== 2'd1) begin errors++; $display("FAIL step_black_scene got %0d want 1", scene); end
    checks++; if (fade !== 2'd0) begin errors++; $display("FAIL step_black_fade got %0d want 0", fade); end
    do_reset();
    frames(11);
    pulse_step();
    frames(1);
    checks++; if (fade !== 2'd2) begin errors++; $display("FAIL step_fo_fade got %0d want 2", fade); end
    frames(4);
    checks++; if (scene !== 2'd0) begin errors++; $display("FAIL step_fo_scene16 got %0d want 0", scene); end
    frames(1);
    checks++; if (scene !== 2'd1) begin errors++; $display("FAIL step_fo_scene17 got %0d want 1", scene); end
  endtask
  task automatic test_pause();
    do_reset();
    frames(7);
    pause = 1'b1;
    repeat (4) @(negedge clk);
    p0 = pulses;
    frames(4);
    pulse_step();
    frames(6);
    checks++; if (pulses - p0 !== 10) begin errors++; $display("FAIL pause_pulses got %0d want 10", pulses - p0); end
    checks++; if (fade !== 2'd3) begin errors++; $display("FAIL pause_fade got %0d want 3", fade); end
    checks++; if (scene !== 2'd0) begin errors++; $display("FAIL pause_scene got %0d want 0", scene); end
    checks++; if (scroll_x !== 10'd7) begin errors++; $display("FAIL pause_scroll got %0d want 7", scroll_x); end
    pause = 1'b0;
    repeat (4) @(negedge clk);
    frames(1);
    checks++; if (scroll_x !== 10'd8) begin errors++; $display("FAIL pause_resume_scroll got %0d want 8", scroll_x); end
    frames(2);
    checks++; if (fade !== 2'd2) begin errors++; $display("FAIL pause_step_applied got %0d want 2", fade); end
  endtask
  task automatic test_async_reset();
    do_reset();
    frames(8);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++; if ({frame_tick, scene, fade, scroll_x} !== 15'd0) begin errors++; $display("FAIL async_reset got %0h want 0", {frame_tick, scene, fade, scroll_x}); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    frames(1);
    checks++; if (fade !== 2'd0) begin errors++; $display("FAIL restart_t1 got %0d want 0", fade); end
    frames(1);
    checks++; if (fade !== 2'd1) begin errors++; $display("FAIL restart_t2 got %0d want 1", fade); end
  endtask
  initial begin
    test_reset();
    test_sequence();
    test_scroll();
    test_step();
    test_pause();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
